// File: rtl/nibble_add_pkg.sv
// rtl/nibble_add_pkg.sv - shared state encoding and nibble width for the serial adder
package nibble_add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add4_nibble.sv
// rtl/add4_nibble.sv - combinational 4-bit full adder datapath
module add4_nibble
    import nibble_add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             c_in,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, c_in};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - sequences one 4-bit adder over WIDTH-bit operands, LS nibble first
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_r;
    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] nib_s;
    logic             nib_c;

    assign last  = (idx == IDX_LAST);
    assign nib_a = op_a[idx*NIB_W +: NIB_W];
    assign nib_b = op_b[idx*NIB_W +: NIB_W];

    add4_nibble u_add4 (
        .a    (nib_a),
        .b    (nib_b),
        .c_in (carry_r),
        .sum  (nib_s),
        .cout (nib_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            carry_r <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            op_a    <= a;
            op_b    <= b;
            carry_r <= c_in;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (state == RUN) begin
            sum[idx*NIB_W +: NIB_W] <= nib_s;
            carry_r                 <= nib_c;
            if (last) begin
                cout <= nib_c;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - randomized self-checking bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_errors = 0;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic ci);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    endfunction

    // Called on a negedge with the DUT in IDLE or DONE; returns on the negedge where done is high.
    task automatic run_add(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc,
                           input bit poke_in_run, input string tag);
        logic [WIDTH:0] exp;
        int edges;
        int busy_cnt;
        bit got_done;
        exp      = ref_add(xa, xb, xc);
        a        = xa;
        b        = xb;
        c_in     = xc;
        start    = 1'b1;
        edges    = 0;
        busy_cnt = 0;
        got_done = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) begin
                start = 1'b0;
                a     = 16'($urandom);
                b     = 16'($urandom);
                check({tag, " cleared sum"}, 32'(sum), 32'h0);
                check({tag, " busy first"}, 32'(busy), 32'h1);
            end
            if (poke_in_run && edges == 2) begin
                start = 1'b1;
                c_in  = ~xc;
            end
            if (poke_in_run && edges == 3) begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) got_done = 1'b1;
        end
        check({tag, " done seen"}, 32'(got_done), 32'h1);
        check({tag, " latency"}, 32'(edges), 32'(NIB + 1));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(NIB));
        check({tag, " sum"}, 32'(sum), 32'(exp[WIDTH-1:0]));
        check({tag, " cout"}, 32'(cout), 32'(exp[WIDTH]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic rc;
        logic [WIDTH:0] e;

        #2;
        check("reset sum", 32'(sum), 32'h0);
        check("reset cout", 32'(cout), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle hold", 32'({busy, done, cout, sum}), 32'h0);
        end

        run_add(16'h1234, 16'h1111, 1'b0, 1'b0, "basic");
        check("basic value", 32'(sum), 32'h2345);
        @(negedge clk);
        check("basic done pulse", 32'(done), 32'h0);
        check("basic hold sum", 32'(sum), 32'h2345);

        run_add(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple");
        check("ripple value", 32'({cout, sum}), 32'h10000);
        @(negedge clk);

        run_add(16'h7777, 16'h7777, 1'b1, 1'b0, "b2b first");
        check("b2b first value", 32'({cout, sum}), 32'h0EEEF);
        run_add(16'h8000, 16'h8000, 1'b0, 1'b0, "b2b second");
        check("b2b second value", 32'({cout, sum}), 32'h10000);
        @(negedge clk);

        run_add(16'h0F0F, 16'h00F1, 1'b0, 1'b1, "ignore");
        check("ignore value", 32'({cout, sum}), 32'h01000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ignore single done", 32'(done), 32'h0);
            check("ignore no restart", 32'(busy), 32'h0);
        end

        a     = 16'h1234;
        b     = 16'h1111;
        c_in  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst sum", 32'(sum), 32'h0);
        check("async rst busy", 32'(busy), 32'h0);
        check("async rst flags", 32'({done, cout}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post rst idle", 32'({busy, done}), 32'h0);
        end
        run_add(16'h0005, 16'h0007, 1'b0, 1'b0, "post rst");
        check("post rst value", 32'({cout, sum}), 32'h0000C);
        @(negedge clk);

        for (int n = 0; n < 20; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            e  = ref_add(ra, rb, rc);
            run_add(ra, rb, rc, 1'($urandom_range(0, 1)), "rand");
            if (($urandom & 1) != 0) @(negedge clk);
            check("rand model", 32'({cout, sum}), 32'(e));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
